// File: rtl/game_pkg.sv
// Shared types and constants for the sprite movement logic.
package game_pkg;

    localparam int unsigned COORD_X_W    = 11;
    localparam int unsigned COORD_Y_W    = 10;
    localparam int unsigned CALC_W       = 13;
    localparam int unsigned SCREEN_MAX_X = 1279;
    localparam int unsigned SCREEN_MAX_Y = 799;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CALC,
        COMMIT
    } move_state_t;

    // Opposing buttons pressed together cancel on that axis.
    function automatic dir_t resolve_dir(input dir_t d);
        dir_t r;
        r = d;
        if (d.up && d.down) begin
            r.up   = 1'b0;
            r.down = 1'b0;
        end
        if (d.left && d.right) begin
            r.left  = 1'b0;
            r.right = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// N-bit two-flop synchroniser for asynchronous button inputs.
module btn_sync #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sprite_move_ctrl.sv
// Frame-synchronous sprite movement controller with on-screen clamping.
// Optional acceleration enabled by defining SPRITE_MOVE_ACCEL_EN.
module sprite_move_ctrl
    import game_pkg::*;
#(
    parameter int unsigned MAX_X           = SCREEN_MAX_X,
    parameter int unsigned MAX_Y           = SCREEN_MAX_Y,
    parameter int unsigned SPR_W           = 140,
    parameter int unsigned SPR_H           = 100,
    parameter int unsigned STEP            = 1,
    parameter int unsigned FRAMES_PER_MOVE = 1,
    parameter int unsigned START_X         = 520,
    parameter int unsigned START_Y         = 300
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_up,
    input  logic                 in_down,
    input  logic                 in_left,
    input  logic                 in_right,
    input  logic                 vblank_start,
    output logic [COORD_X_W-1:0] pos_x,
    output logic [COORD_Y_W-1:0] pos_y,
    output logic                 pos_valid,
    output logic                 moving
);

    localparam int unsigned LIM_X    = MAX_X - SPR_W + 1;
    localparam int unsigned LIM_Y    = MAX_Y - SPR_H + 1;
    localparam int unsigned FCNT_W   = 8;
    localparam logic [FCNT_W-1:0] FPM_LAST = FCNT_W'(FRAMES_PER_MOVE - 1);

    logic [3:0]           btn_s;
    dir_t                 btn_dir_c;
    dir_t                 dir_new_c;
    dir_t                 dir;
    move_state_t          state;
    logic [FCNT_W-1:0]    frame_cnt;
    logic [COORD_X_W-1:0] nx_q;
    logic [COORD_Y_W-1:0] ny_q;

    logic signed [CALC_W-1:0] step_c;
    logic signed [CALC_W-1:0] cur_x_c, cur_y_c, nx_raw_c, ny_raw_c;
    logic [COORD_X_W-1:0]     nx_clamp_c;
    logic [COORD_Y_W-1:0]     ny_clamp_c;

    btn_sync #(.N(4)) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   ({in_up, in_down, in_left, in_right}),
        .q   (btn_s)
    );

    assign btn_dir_c = dir_t'(btn_s);
    assign dir_new_c = resolve_dir(btn_dir_c);

`ifdef SPRITE_MOVE_ACCEL_EN
    logic [2:0] run_cnt;
    logic [1:0] step_sh;
    assign step_c = $signed(CALC_W'(STEP) << step_sh);
`else
    assign step_c = $signed(CALC_W'(STEP));
`endif

    // Next position from the latched direction, clamped so the sprite stays visible.
    always_comb begin
        cur_x_c  = $signed(CALC_W'(pos_x));
        cur_y_c  = $signed(CALC_W'(pos_y));
        nx_raw_c = cur_x_c;
        ny_raw_c = cur_y_c;
        if (dir.right)     nx_raw_c = cur_x_c + step_c;
        else if (dir.left) nx_raw_c = cur_x_c - step_c;
        if (dir.down)      ny_raw_c = cur_y_c + step_c;
        else if (dir.up)   ny_raw_c = cur_y_c - step_c;

        if (nx_raw_c[CALC_W-1])                       nx_clamp_c = '0;
        else if (nx_raw_c > $signed(CALC_W'(LIM_X)))  nx_clamp_c = COORD_X_W'(LIM_X);
        else                                          nx_clamp_c = COORD_X_W'(nx_raw_c);

        if (ny_raw_c[CALC_W-1])                       ny_clamp_c = '0;
        else if (ny_raw_c > $signed(CALC_W'(LIM_Y)))  ny_clamp_c = COORD_Y_W'(LIM_Y);
        else                                          ny_clamp_c = COORD_Y_W'(ny_raw_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            dir       <= '0;
            nx_q      <= COORD_X_W'(START_X);
            ny_q      <= COORD_Y_W'(START_Y);
            pos_x     <= COORD_X_W'(START_X);
            pos_y     <= COORD_Y_W'(START_Y);
            pos_valid <= 1'b0;
            moving    <= 1'b0;
`ifdef SPRITE_MOVE_ACCEL_EN
            run_cnt   <= '0;
            step_sh   <= '0;
`endif
        end else begin
            pos_valid <= 1'b0;
            case (state)
                // vblank pulses are only counted here; elsewhere they are dropped.
                IDLE: begin
                    if (vblank_start) begin
                        if (frame_cnt == FPM_LAST) begin
                            frame_cnt <= '0;
                            state     <= SAMPLE;
                        end else begin
                            frame_cnt <= frame_cnt + FCNT_W'(1);
                        end
                    end
                end
                SAMPLE: begin
                    dir   <= dir_new_c;
                    state <= CALC;
`ifdef SPRITE_MOVE_ACCEL_EN
                    if ((dir_new_c != '0) && (dir_new_c == dir)) begin
                        run_cnt <= run_cnt + 3'd1;
                        if ((run_cnt == 3'd7) && (step_sh != 2'd3))
                            step_sh <= step_sh + 2'd1;
                    end else begin
                        run_cnt <= '0;
                        step_sh <= '0;
                    end
`endif
                end
                CALC: begin
                    nx_q  <= nx_clamp_c;
                    ny_q  <= ny_clamp_c;
                    state <= COMMIT;
                end
                COMMIT: begin
                    pos_x     <= nx_q;
                    pos_y     <= ny_q;
                    moving    <= (nx_q != pos_x) || (ny_q != pos_y);
                    pos_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
